sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and default sizing for the display/renderer SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W       = 20;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  typedef logic [DEF_ADDR_W-1:0] SramAddress_t;
  typedef logic [DEF_DATA_W-1:0] SramData_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4
  } SramArbState_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-cycle async-SRAM arbiter: display scanout reads vs. renderer reads/writes.
// Optional renderer starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              rend_req,
  input  logic              rend_wren,
  input  logic [ADDR_W-1:0] rend_addr,
  input  logic [DATA_W-1:0] rend_wdata,
  output logic              rend_ack,
  output logic [DATA_W-1:0] rend_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  SramArbState_t state, nextState;
  logic ownerRend;
  logic arbSlot, dispElig, rendElig, grantDisp, grantRend, starve;
  logic ceNext, oeNext, weNext, doeNext, dispAckNext, rendAckNext;

  // A zero limit would make the guard hand every contested slot to the renderer.
  if (STARVE_LIMIT == 0) begin : gLimitCheck
    $error("STARVE_LIMIT must be nonzero");
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starveCnt;

  assign starve = (starveCnt >= CNT_W'(STARVE_LIMIT));

  // Counts display wins while the renderer is kept waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (grantRend || !rend_req) begin
      starveCnt <= '0;
    end else if (grantDisp && !starve) begin
      starveCnt <= starveCnt + CNT_W'(1);
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Arbitration, next state and next registered strobes.
  always_comb begin
    nextState = state;
    grantDisp = 1'b0;
    grantRend = 1'b0;
    arbSlot   = (state == IDLE) || (state == RD2) || (state == WR2);
    // The requester in its ack cycle still holds req; keep it out of this round.
    dispElig  = disp_req && !((state == RD2) && !ownerRend);
    rendElig  = rend_req && !(((state == RD2) || (state == WR2)) && ownerRend);

    if (arbSlot) begin
      if (starve && rendElig)  grantRend = 1'b1;
      else if (dispElig)       grantDisp = 1'b1;
      else if (rendElig)       grantRend = 1'b1;
    end

    unique case (state)
      IDLE, RD2, WR2: begin
        if (grantDisp)      nextState = RD1;
        else if (grantRend) nextState = rend_wren ? WR1 : RD1;
        else                nextState = IDLE;
      end
      RD1:     nextState = RD2;
      WR1:     nextState = WR2;
      default: nextState = IDLE;
    endcase

    ceNext      = (nextState == IDLE);
    oeNext      = !((nextState == RD1) || (nextState == RD2));
    weNext      = (nextState != WR1);
    doeNext     = (nextState == WR1) || (nextState == WR2);
    dispAckNext = (state == RD1) && !ownerRend;
    rendAckNext = ((state == RD1) || (state == WR1)) && ownerRend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Registered SRAM interface, acks and per-requester read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerRend  <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_doe   <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      disp_ack   <= 1'b0;
      rend_ack   <= 1'b0;
      disp_rdata <= '0;
      rend_rdata <= '0;
    end else begin
      sram_ce_n <= ceNext;
      sram_oe_n <= oeNext;
      sram_we_n <= weNext;
      sram_doe  <= doeNext;
      disp_ack  <= dispAckNext;
      rend_ack  <= rendAckNext;
      if (state == RD1) begin
        if (ownerRend) rend_rdata <= sram_din;
        else           disp_rdata <= sram_din;
      end
      if (grantDisp) begin
        ownerRend <= 1'b0;
        sram_addr <= disp_addr;
      end else if (grantRend) begin
        ownerRend <= 1'b1;
        sram_addr <= rend_addr;
        if (rend_wren) sram_dout <= rend_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, reset-abort sequence,
// and randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned LIMIT = 8;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [5:0] C_IDLE = 6'b001110;
  localparam logic [5:0] C_RD1  = 6'b000010;
  localparam logic [5:0] C_RD2D = 6'b100010;
  localparam logic [5:0] C_RD2R = 6'b010010;
  localparam logic [5:0] C_WR1  = 6'b000101;
  localparam logic [5:0] C_WR2  = 6'b010111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dReq = 1'b0, rReq = 1'b0, rWr = 1'b0;
  logic [AW-1:0] dAddr = '0, rAddr = '0;
  logic [DW-1:0] rWd = '0, din = '0;
  logic dAck, rAck, doe, ceN, oeN, weN;
  logic [DW-1:0] dRd, rRd, dout;
  logic [AW-1:0] addr;

  int passCnt = 0;
  int checkCnt = 0;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(dReq), .disp_addr(dAddr), .disp_ack(dAck), .disp_rdata(dRd),
    .rend_req(rReq), .rend_wren(rWr), .rend_addr(rAddr), .rend_wdata(rWd),
    .rend_ack(rAck), .rend_rdata(rRd),
    .sram_addr(addr), .sram_dout(dout), .sram_doe(doe), .sram_din(din),
    .sram_ce_n(ceN), .sram_oe_n(oeN), .sram_we_n(weN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          dReq;
    logic [AW-1:0] dAddr;
    logic          rReq;
    logic          rWr;
    logic [AW-1:0] rAddr;
    logic [DW-1:0] rWd;
    logic [DW-1:0] din;
    logic [5:0]    ctl;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic [DW-1:0] dRd;
    logic [DW-1:0] rRd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic dq, logic [AW-1:0] da, logic rq, logic rw,
                              logic [AW-1:0] ra, logic [DW-1:0] wd, logic [DW-1:0] di,
                              logic [5:0] c, logic [AW-1:0] a, logic [DW-1:0] o,
                              logic [DW-1:0] dr, logic [DW-1:0] rr);
    vec_t v;
    v.dReq = dq; v.dAddr = da; v.rReq = rq; v.rWr = rw; v.rAddr = ra; v.rWd = wd;
    v.din = di; v.ctl = c; v.addr = a; v.dout = o; v.dRd = dr; v.rRd = rr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctlNow();
    return {dAck, rAck, ceN, oeN, weN, doe};
  endfunction

  // Reference model: one access record with an age of 1 (strobe cycle) or 2 (ack cycle).
  bit mActv, mOwn, mWr;
  int mAge, mCnt;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mDout, mDr, mRr;

  task automatic modelReset();
    mActv = 0; mOwn = 0; mWr = 0; mAge = 0; mCnt = 0;
    mAddr = '0; mDout = '0; mDr = '0; mRr = '0;
  endtask

  task automatic modelStep();
    bit dEl, rEl, gD, gR, starveNow;
    gD = 0; gR = 0;
    starveNow = GUARD && (mCnt >= LIMIT);
    if (mActv && mAge == 1) begin
      if (!mWr) begin
        if (mOwn) mRr = din;
        else      mDr = din;
      end
      mAge = 2;
    end else begin
      dEl = dReq && !(mActv && !mOwn);
      rEl = rReq && !(mActv && mOwn);
      if (starveNow && rEl) gR = 1;
      else if (dEl)         gD = 1;
      else if (rEl)         gR = 1;
      mActv = gD || gR;
      mAge = 1;
      if (gD) begin
        mOwn = 0; mWr = 0; mAddr = dAddr;
      end else if (gR) begin
        mOwn = 1; mWr = rWr; mAddr = rAddr;
        if (rWr) mDout = rWd;
      end
    end
    if (!rReq || gR) mCnt = 0;
    else if (gD && mCnt < LIMIT) mCnt++;
  endtask

  function automatic logic [5:0] modelCtl();
    if (!mActv) return C_IDLE;
    if (mAge == 1) return mWr ? C_WR1 : C_RD1;
    return {!mOwn, mOwn, 1'b0, mWr, 1'b1, mWr};
  endfunction

  initial begin
    vec_t v;
    bit dRel, rRel;
    logic [5:0] ec;

    // Async reset check before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset ctl", 64'(ctlNow()), 64'(C_IDLE));
    chk("reset addr", 64'(addr), 64'h0);
    chk("reset dout", 64'(dout), 64'h0);
    chk("reset rdata", {dRd, rRd}, 64'h0);
    step();
    rst = 1'b0;

    //         dq  dAddr   rq rw rAddr   wdata         din           ctl     addr    dout          dRd           rRd
    vecs.push_back(mk(0, 20'h0,  0, 0, 20'h0,  32'h0,        32'h0,        C_IDLE, 20'h0,  32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 20'h0,  1, 1, 20'h10, 32'hDEADBEEF, 32'h0,        C_WR1,  20'h10, 32'hDEADBEEF, 32'h0,        32'h0));
    vecs.push_back(mk(0, 20'h0,  1, 1, 20'h10, 32'hDEADBEEF, 32'h0,        C_WR2,  20'h10, 32'hDEADBEEF, 32'h0,        32'h0));
    vecs.push_back(mk(0, 20'h0,  0, 0, 20'h0,  32'h0,        32'h0,        C_IDLE, 20'h10, 32'hDEADBEEF, 32'h0,        32'h0));
    vecs.push_back(mk(1, 20'h20, 1, 1, 20'h44, 32'hCAFEF00D, 32'hA5A5A5A5, C_RD1,  20'h20, 32'hDEADBEEF, 32'h0,        32'h0));
    vecs.push_back(mk(1, 20'h20, 1, 1, 20'h44, 32'hCAFEF00D, 32'hA5A5A5A5, C_RD2D, 20'h20, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(0, 20'h0,  1, 1, 20'h44, 32'hCAFEF00D, 32'h0,        C_WR1,  20'h44, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(0, 20'h0,  1, 1, 20'h44, 32'hCAFEF00D, 32'h0,        C_WR2,  20'h44, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(0, 20'h0,  0, 0, 20'h0,  32'h0,        32'h0,        C_IDLE, 20'h44, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 20'h30, 0, 0, 20'h0,  32'h0,        32'h0,        C_RD1,  20'h30, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 20'h30, 0, 0, 20'h0,  32'h0,        32'h12345678, C_RD2D, 20'h30, 32'hCAFEF00D, 32'h12345678, 32'h0));
    vecs.push_back(mk(0, 20'h0,  0, 0, 20'h0,  32'h0,        32'h0,        C_IDLE, 20'h30, 32'hCAFEF00D, 32'h12345678, 32'h0));
    vecs.push_back(mk(0, 20'h0,  1, 0, 20'h55, 32'h0,        32'h0,        C_RD1,  20'h55, 32'hCAFEF00D, 32'h12345678, 32'h0));
    vecs.push_back(mk(0, 20'h0,  1, 0, 20'h55, 32'h0,        32'h0BADF00D, C_RD2R, 20'h55, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D));
    vecs.push_back(mk(0, 20'h0,  1, 0, 20'h56, 32'h0,        32'h0,        C_IDLE, 20'h55, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D));
    vecs.push_back(mk(0, 20'h0,  1, 0, 20'h56, 32'h0,        32'h0,        C_RD1,  20'h56, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D));
    vecs.push_back(mk(0, 20'h0,  1, 0, 20'h56, 32'h0,        32'h77,       C_RD2R, 20'h56, 32'hCAFEF00D, 32'h12345678, 32'h77));
    vecs.push_back(mk(0, 20'h0,  0, 0, 20'h0,  32'h0,        32'h0,        C_IDLE, 20'h56, 32'hCAFEF00D, 32'h12345678, 32'h77));
    vecs.push_back(mk(1, 20'h60, 1, 0, 20'h61, 32'h0,        32'h0,        C_RD1,  20'h60, 32'hCAFEF00D, 32'h12345678, 32'h77));
    vecs.push_back(mk(1, 20'h60, 1, 0, 20'h61, 32'h0,        32'h1,        C_RD2D, 20'h60, 32'hCAFEF00D, 32'h1,        32'h77));
    vecs.push_back(mk(1, 20'h62, 1, 0, 20'h61, 32'h0,        32'h0,        C_RD1,  20'h61, 32'hCAFEF00D, 32'h1,        32'h77));
    vecs.push_back(mk(1, 20'h62, 1, 0, 20'h61, 32'h0,        32'h2,        C_RD2R, 20'h61, 32'hCAFEF00D, 32'h1,        32'h2));
    vecs.push_back(mk(1, 20'h62, 1, 0, 20'h63, 32'h0,        32'h0,        C_RD1,  20'h62, 32'hCAFEF00D, 32'h1,        32'h2));
    vecs.push_back(mk(1, 20'h62, 1, 0, 20'h63, 32'h0,        32'h3,        C_RD2D, 20'h62, 32'hCAFEF00D, 32'h3,        32'h2));
    vecs.push_back(mk(1, 20'h64, 1, 0, 20'h63, 32'h0,        32'h0,        C_RD1,  20'h63, 32'hCAFEF00D, 32'h3,        32'h2));
    vecs.push_back(mk(1, 20'h64, 1, 0, 20'h63, 32'h0,        32'h4,        C_RD2R, 20'h63, 32'hCAFEF00D, 32'h3,        32'h4));
    vecs.push_back(mk(1, 20'h64, 0, 0, 20'h0,  32'h0,        32'h0,        C_RD1,  20'h64, 32'hCAFEF00D, 32'h3,        32'h4));
    vecs.push_back(mk(1, 20'h64, 0, 0, 20'h0,  32'h0,        32'h5,        C_RD2D, 20'h64, 32'hCAFEF00D, 32'h5,        32'h4));
    vecs.push_back(mk(0, 20'h0,  0, 0, 20'h0,  32'h0,        32'h0,        C_IDLE, 20'h64, 32'hCAFEF00D, 32'h5,        32'h4));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      dReq = v.dReq; dAddr = v.dAddr; rReq = v.rReq; rWr = v.rWr;
      rAddr = v.rAddr; rWd = v.rWd; din = v.din;
      step();
      chk($sformatf("vec%0d ctl", i), 64'(ctlNow()), 64'(v.ctl));
      chk($sformatf("vec%0d addr", i), 64'(addr), 64'(v.addr));
      chk($sformatf("vec%0d dout", i), 64'(dout), 64'(v.dout));
      chk($sformatf("vec%0d rdata", i), {dRd, rRd}, {v.dRd, v.rRd});
    end

    // Reset during WR1 aborts the write; the held request is then served afresh.
    rReq = 1; rWr = 1; rAddr = 20'h70; rWd = 32'h11111111;
    step();
    chk("abort pre ctl", 64'(ctlNow()), 64'(C_WR1));
    #2 rst = 1'b1;
    #1;
    chk("abort async ctl", 64'(ctlNow()), 64'(C_IDLE));
    chk("abort async addr", 64'(addr), 64'h0);
    chk("abort async dout", 64'(dout), 64'h0);
    step();
    chk("abort held ctl", 64'(ctlNow()), 64'(C_IDLE));
    rst = 1'b0;
    step();
    chk("rearb wr1 ctl", 64'(ctlNow()), 64'(C_WR1));
    chk("rearb wr1 addr", 64'(addr), 64'h70);
    chk("rearb wr1 dout", 64'(dout), 64'h11111111);
    step();
    chk("rearb wr2 ctl", 64'(ctlNow()), 64'(C_WR2));
    rReq = 0;
    step();
    chk("rearb idle ctl", 64'(ctlNow()), 64'(C_IDLE));

    // Randomized traffic against the reference model.
    dReq = 0; rReq = 0; rWr = 0; dAddr = '0; rAddr = '0; rWd = '0; din = '0;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    modelReset();
    dRel = 0; rRel = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      modelStep();
      ec = modelCtl();
      chk($sformatf("rand%0d ctl", c), 64'(ctlNow()), 64'(ec));
      if (mActv) begin
        chk($sformatf("rand%0d addr", c), 64'(addr), 64'(mAddr));
        chk($sformatf("rand%0d dout", c), 64'(dout), 64'(mDout));
      end
      chk($sformatf("rand%0d rdata", c), {dRd, rRd}, {mDr, mRr});
      if (!dReq || dRel) begin
        dReq = ($urandom_range(0, 1) == 1);
        dAddr = AW'($urandom);
      end
      if (!rReq || rRel) begin
        rReq = ($urandom_range(0, 3) != 0);
        rWr = ($urandom_range(0, 1) == 1);
        rAddr = AW'($urandom);
        rWd = $urandom;
      end
      dRel = (ec[5] == 1'b1);
      rRel = (ec[4] == 1'b1);
      din = $urandom;
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
